// File: rtl/oled_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | oled_pkg: shared types and constants for OLED character arbiters.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package oled_pkg;

    localparam int c_BYTE_W        = 8;
    localparam int c_DEF_NUM_REQ   = 4;
    localparam int c_DEF_MAX_BURST = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick: combinational round-robin winner selection.                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [ID_W-1:0]    win_o,
    output logic               any_req_o
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    int                   w_sum;

    // Bit k of w_rot is the requester sitting k places after the pointer.
    assign w_dbl     = {req_i, req_i};
    assign w_rot     = NUM_REQ'(w_dbl >> rr_ptr_i);
    assign any_req_o = |req_i;

    always_comb begin
        win_o = '0;
        w_sum = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = int'(rr_ptr_i) + k;
                if (w_sum >= NUM_REQ) begin
                    w_sum = w_sum - NUM_REQ;
                end
                win_o = ID_W'(w_sum);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/oled_char_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | oled_char_arbiter: message-granular round-robin sharing of the     |
// | oledControl character interface between NUM_REQ producers.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module oled_char_arbiter
    import oled_pkg::*;
#(
    parameter int NUM_REQ   = c_DEF_NUM_REQ,
    parameter int MAX_BURST = c_DEF_MAX_BURST,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*c_BYTE_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [c_BYTE_W-1:0]          send_data,
    output logic                         send_data_valid,
    input  logic                         send_done,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy,
    output logic                         msg_done
);

    localparam logic [7:0] c_MAX_BURST = 8'(MAX_BURST);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [c_BYTE_W-1:0]   data_q, data_d;
    logic                  valid_q, valid_d;
    logic [NUM_REQ-1:0]    ready_q, ready_d;
    logic                  last_q, last_d;
    logic [7:0]            burst_q, burst_d;
    logic                  done_q, done_d;

    logic [ID_W-1:0]       w_win;
    logic                  w_any;
    logic [ID_W-1:0]       w_sel_id;
    logic [ID_W-1:0]       w_next_ptr;
    logic [c_BYTE_W-1:0]   w_bytes [NUM_REQ];

    genvar g;
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_bytes[g] = req_data[g*c_BYTE_W +: c_BYTE_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_i     (req_valid),
        .rr_ptr_i  (rr_q),
        .win_o     (w_win),
        .any_req_o (w_any)
    );

    // A new grant comes from the picker; a continuing message reuses the holder.
    assign w_sel_id   = (state_q == ST_IDLE) ? w_win : grant_q;
    assign w_next_ptr = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= '0;
            last_q  <= 1'b0;
            burst_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        data_d  = data_q;
        valid_d = valid_q;
        ready_d = '0;
        last_d  = last_q;
        burst_d = burst_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!send_done && w_any) begin
                    grant_d = w_sel_id;
                    data_d  = w_bytes[w_sel_id];
                    last_d  = req_last[w_sel_id];
                    ready_d = NUM_REQ'(1) << w_sel_id;
                    burst_d = 8'd1;
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (send_done) begin
                    valid_d = 1'b0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // Release beats continuation; an idle holder keeps the grant.
                if (!send_done) begin
                    if (last_q || (burst_q == c_MAX_BURST)) begin
                        done_d  = 1'b1;
                        rr_d    = w_next_ptr;
                        state_d = ST_IDLE;
                    end else if (req_valid[grant_q]) begin
                        data_d  = w_bytes[w_sel_id];
                        last_d  = req_last[w_sel_id];
                        ready_d = NUM_REQ'(1) << w_sel_id;
                        burst_d = burst_q + 8'd1;
                        valid_d = 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready       = ready_q;
        send_data       = data_q;
        send_data_valid = valid_q;
        grant_id        = grant_q;
        busy            = (state_q != ST_IDLE);
        msg_done        = done_q;
    end

endmodule
`default_nettype wire
